// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side conditions in, pipeline-register controls out.
// Optional counter ports exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
   logic [4:0]  if_id_reg_rs1_adr;
   logic [4:0]  if_id_reg_rs2_adr;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  id_ex_reg_rd_adr;
   logic        id_ex_reg_mem_ctrl_MemRead;
   logic        ex_stage_branch;
   logic        mem_stage_req;
   logic        mem_stage_ready;
   logic        pc_en;
   logic        if_id_en;
   logic        if_id_flush;
   logic        id_ex_en;
   logic        id_ex_flush;
   logic        ex_mem_en;
   logic        mem_wb_bubble;
   logic [1:0]  hazard_state;
   logic        mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output if_id_reg_rs1_adr, if_id_reg_rs2_adr, id_uses_rs1, id_uses_rs2,
             id_ex_reg_rd_adr, id_ex_reg_mem_ctrl_MemRead, ex_stage_branch,
             mem_stage_req, mem_stage_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             mem_wb_bubble, hazard_state, mem_timeout_err, stall_cnt, flush_cnt
   );
   modport slave (
      input  if_id_reg_rs1_adr, if_id_reg_rs2_adr, id_uses_rs1, id_uses_rs2,
             id_ex_reg_rd_adr, id_ex_reg_mem_ctrl_MemRead, ex_stage_branch,
             mem_stage_req, mem_stage_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             mem_wb_bubble, hazard_state, mem_timeout_err, stall_cnt, flush_cnt
   );
`else
   modport master (
      output if_id_reg_rs1_adr, if_id_reg_rs2_adr, id_uses_rs1, id_uses_rs2,
             id_ex_reg_rd_adr, id_ex_reg_mem_ctrl_MemRead, ex_stage_branch,
             mem_stage_req, mem_stage_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             mem_wb_bubble, hazard_state, mem_timeout_err
   );
   modport slave (
      input  if_id_reg_rs1_adr, if_id_reg_rs2_adr, id_uses_rs1, id_uses_rs2,
             id_ex_reg_rd_adr, id_ex_reg_mem_ctrl_MemRead, ex_stage_branch,
             mem_stage_req, mem_stage_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             mem_wb_bubble, hazard_state, mem_timeout_err
   );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait > branch > load-use > run, with cause record,
// memory-wait watchdog and optional perf counters (macro HAZARD_PERF_CNT_EN).
module hazard_ctrl #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_FLUSH      = 2'b10,
      ST_MEM_WAIT   = 2'b11
   } hz_state_e;

   hz_state_e  cause_s;
   hz_state_e  state_q, state_d;
   logic       mem_wait_s;
   logic       luh_s;
   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       err_q, err_d;

   assign mem_wait_s = hz.mem_stage_req & ~hz.mem_stage_ready;
   assign luh_s = hz.id_ex_reg_mem_ctrl_MemRead & (hz.id_ex_reg_rd_adr != 5'd0) &
                  ((hz.id_uses_rs1 & (hz.if_id_reg_rs1_adr == hz.id_ex_reg_rd_adr)) |
                   (hz.id_uses_rs2 & (hz.if_id_reg_rs2_adr == hz.id_ex_reg_rd_adr)));

   // Resolve the cause applied this cycle in priority order.
   always_comb begin
      cause_s = ST_RUN;
      if (mem_wait_s) begin
         cause_s = ST_MEM_WAIT;
      end else if (hz.ex_stage_branch) begin
         cause_s = ST_FLUSH;
      end else if (luh_s) begin
         cause_s = ST_LOAD_STALL;
      end else begin
         cause_s = ST_RUN;
      end
   end

   // Pipeline-register controls; reset forces every stage into a bubble.
   always_comb begin
      hz.pc_en         = 1'b1;
      hz.if_id_en      = 1'b1;
      hz.if_id_flush   = 1'b0;
      hz.id_ex_en      = 1'b1;
      hz.id_ex_flush   = 1'b0;
      hz.ex_mem_en     = 1'b1;
      hz.mem_wb_bubble = 1'b0;
      if (!rst_n) begin
         hz.pc_en         = 1'b0;
         hz.if_id_en      = 1'b0;
         hz.if_id_flush   = 1'b1;
         hz.id_ex_en      = 1'b0;
         hz.id_ex_flush   = 1'b1;
         hz.ex_mem_en     = 1'b0;
         hz.mem_wb_bubble = 1'b1;
      end else begin
         case (cause_s)
            ST_MEM_WAIT: begin
               hz.pc_en         = 1'b0;
               hz.if_id_en      = 1'b0;
               hz.id_ex_en      = 1'b0;
               hz.ex_mem_en     = 1'b0;
               hz.mem_wb_bubble = 1'b1;
            end
            ST_FLUSH: begin
               hz.if_id_flush = 1'b1;
               hz.id_ex_flush = 1'b1;
            end
            ST_LOAD_STALL: begin
               hz.pc_en       = 1'b0;
               hz.if_id_en    = 1'b0;
               hz.id_ex_flush = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state for the cause record and the watchdog.
   always_comb begin
      state_d  = cause_s;
      wd_cnt_d = 8'd0;
      err_d    = err_q;
      if (mem_wait_s) begin
         wd_cnt_d = (wd_cnt_q == 8'd255) ? 8'd255 : (wd_cnt_q + 8'd1);
         if (wd_cnt_d == MEM_TIMEOUT) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         wd_cnt_d = 8'd0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         wd_cnt_q <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign hz.hazard_state    = state_q;
   assign hz.mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Stall and flush event counters, free-running with natural wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if ((cause_s == ST_LOAD_STALL) || (cause_s == ST_MEM_WAIT)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (cause_s == ST_FLUSH) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
